jk_mode_counter: RTL
====================

Name: jk_mode_counter

Overview:
- Parametrised, fully synchronous WIDTH-bit register bank with four operating modes.
- Modes: per-bit JK flip-flop operation, modulo-MOD up count, modulo-MOD down count, and parallel load.
- Replaces single-bit JK flip-flops and ripple (asynchronous) counter chains with one single-clock block.
- Adds terminal-count and sticky overflow status for counter/timer use in downstream control logic.

Parameters:
- WIDTH, 4, register width in bits (1..32).
- MOD, 16, count modulus (2..2**WIDTH); legal count range is 0..MOD-1.
- WRAP, 1, 1 = wrap at limits; 0 = saturate at limits.
- RST_VAL, 0, value of q_o after reset (must be < 2**WIDTH).

Ports:
- clk_i, input, 1, single clock; all state updates on the rising edge.
- rst_i, input, 1, synchronous active-high reset.
- en_i, input, 1, operation enable; 0 = hold all state except ovf_o clear.
- mode_i, input, 2, 00 = JK, 01 = up, 10 = down, 11 = load.
- j_i, input, WIDTH, per-bit J inputs; used in JK mode only.
- k_i, input, WIDTH, per-bit K inputs; used in JK mode only.
- d_i, input, WIDTH, parallel load data; used in load mode only.
- clr_ovf_i, input, 1, clears ovf_o.
- q_o, output, WIDTH, registered register/count value.
- tc_o, output, 1, registered one-cycle terminal-count pulse.
- ovf_o, output, 1, sticky limit-event flag.

Behaviour:
- Reset: a rising edge with rst_i=1 sets q_o=RST_VAL, tc_o=0, ovf_o=0. Reset has priority over every other input and takes effect mid-operation in any mode.
- Hold: with en_i=0, q_o holds and tc_o=0 the next cycle. clr_ovf_i is still honoured.
- Latency: every operation takes effect one clock edge after its inputs are sampled. There are no combinational paths from inputs to outputs.
- JK mode (00): each bit i is updated independently from {j_i[i],k_i[i]}:
  - 00 = hold
  - 01 = clear
  - 10 = set
  - 11 = toggle
  - Results are not clamped, so q_o may reach MOD..2**WIDTH-1. No tc/ovf event is raised.
- Up mode (01):
  - q < MOD-1: q+1.
  - q >= MOD-1 with WRAP=1: q becomes 0 (limit event).
  - q >= MOD-1 with WRAP=0: q becomes MOD-1 (limit event).
- Down mode (10):
  - 0 < q <= MOD-1: q-1.
  - q > MOD-1 (out of range after JK mode): q becomes MOD-1, with no limit event.
  - q == 0 with WRAP=1: q becomes MOD-1 (limit event).
  - q == 0 with WRAP=0: q holds at 0 (limit event).
- Load mode (11):
  - d_i <= MOD-1: q becomes d_i.
  - d_i > MOD-1: q becomes MOD-1 and a limit event is raised.
- Arithmetic: the next-state value is computed at WIDTH+1 bits and truncated after the limit checks. Behaviour must be correct when MOD == 2**WIDTH.
- Limit event: tc_o=1 for exactly the next cycle. ovf_o is set to 1 and stays set.
- Saturation in consecutive cycles raises a limit event, and therefore a tc_o pulse, every cycle.
- ovf_o clear: clr_ovf_i=1 clears ovf_o on the next edge. If a limit event occurs on the same edge, set wins and ovf_o stays 1.
- Mode changes take effect on the next edge with no idle cycle. Mode values are held in no internal state.

Test Plan:
- Reset: WIDTH=4, MOD=10, RST_VAL=3. Assert rst_i for 1 cycle during up counting -> next cycle q_o=3, tc_o=0, ovf_o=0. Hold rst_i=1 with en_i=1 -> q_o stays 3.
- Up wrap (WRAP=1, MOD=10): from q=0, 10 up cycles -> q_o runs 1..9 then 0. tc_o is high only in the cycle where q_o=0. ovf_o=1 thereafter.
- Down saturate (WRAP=0, MOD=10): from q=2, 4 down cycles -> q_o=1,0,0,0. tc_o is high in the last two cycles. Then clr_ovf_i=1 with no event -> ovf_o=0.
- JK mode (WIDTH=4): q=4'b0101, j=4'b1100, k=4'b1010 -> q_o=4'b1101. Then j=k=4'hF -> q_o=4'b0010. No tc_o pulse occurs in either step.
- Out-of-range recovery (MOD=10):
  - JK-set q to 4'hF, then one up cycle -> q_o=0, tc_o=1.
  - JK-set q to 4'hF, then one down cycle -> q_o=9, tc_o=0.
  - Load d_i=12 -> q_o=9, tc_o=1.
- Enable and simultaneity: en_i=0 with mode=up for 3 cycles -> q_o unchanged, tc_o=0. With clr_ovf_i=1 on the same edge as an up wrap -> ovf_o remains 1.

Source files
------------

// File: rtl/jk_mode_counter.sv
// Single-clock WIDTH-bit register bank: per-bit JK, modulo up/down count and
// parallel load, with a one-cycle terminal-count pulse and a sticky overflow flag.
module jk_mode_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MOD     = 16,
  parameter bit               WRAP    = 1'b1,
  parameter longint unsigned  RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             ovf_o
);

  localparam int unsigned W1 = WIDTH + 1;
  // One extra bit keeps MOD-1 and q+1 representable when MOD == 2**WIDTH.
  localparam logic [W1-1:0] LIM = W1'(MOD - 1);
  localparam logic [W1-1:0] ZERO = '0;
  localparam logic [W1-1:0] ONE = W1'(1);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  mode_t         mode;
  logic [W1-1:0] q_ext;
  logic [W1-1:0] d_ext;
  logic [W1-1:0] nxt;
  logic          evt;
  logic          ovf_nxt;
  logic          unused_nxt_msb;

  assign mode  = mode_t'(mode_i);
  assign q_ext = {1'b0, q_o};
  assign d_ext = {1'b0, d_i};

  always_comb begin
    nxt = q_ext;
    evt = 1'b0;
    if (en_i) begin
      unique case (mode)
        MODE_JK: begin
          nxt = {1'b0, (j_i & ~q_o) | (~k_i & q_o)};
        end
        MODE_UP: begin
          if (q_ext >= LIM) begin
            evt = 1'b1;
            nxt = WRAP ? ZERO : LIM;
          end else begin
            nxt = q_ext + ONE;
          end
        end
        MODE_DOWN: begin
          // Out-of-range values left behind by JK mode snap back silently.
          if (q_ext > LIM) begin
            nxt = LIM;
          end else if (q_ext == ZERO) begin
            evt = 1'b1;
            nxt = WRAP ? LIM : ZERO;
          end else begin
            nxt = q_ext - ONE;
          end
        end
        MODE_LOAD: begin
          if (d_ext > LIM) begin
            evt = 1'b1;
            nxt = LIM;
          end else begin
            nxt = d_ext;
          end
        end
        default: begin
          nxt = q_ext;
        end
      endcase
    end
  end

  // A limit event on the same edge as a clear keeps the flag set.
  assign ovf_nxt = evt | (ovf_o & ~clr_ovf_i);

  assign unused_nxt_msb = nxt[WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o   <= WIDTH'(RST_VAL);
      tc_o  <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      q_o   <= nxt[WIDTH-1:0];
      tc_o  <= evt;
      ovf_o <= ovf_nxt;
    end
  end

endmodule
